// File: rtl/trena_uc_multi.sv
// Control unit for the trena: one sonar measurement, then NUM_CHARS serial characters,
// single-shot or continuous. Define TRENA_TIMEOUT_EN to enable the echo timeout / ERRO state.
module trena_uc_multi #(
  parameter  int NUM_CHARS = 4,
  parameter  int INTERVALO = 50_000_000,
  parameter  int TIMEOUT   = 2_000_000,
  localparam int SEL_W     = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mensurar,
  input  logic             modo,
  input  logic             pronto,
  input  logic             tx_pronto,
  output logic             zera,
  output logic             comeca_medida,
  output logic             tx_partida,
  output logic [SEL_W-1:0] sel_char,
  output logic             fim,
  output logic             erro,
  output logic [3:0]       db_estado
);

  typedef enum logic [3:0] {
    INICIAL   = 4'd0,
    PREPARA   = 4'd1,
    DISPARA   = 4'd2,
    AGUARDA   = 4'd3,
    TRANSMITE = 4'd4,
    ESPERA_TX = 4'd5,
    PROXIMO   = 4'd6,
    FINAL     = 4'd7,
    INTERVALO_ST = 4'd8,
    ERRO      = 4'd9
  } t_estado;

  localparam int                IW      = (INTERVALO > 1) ? $clog2(INTERVALO) : 1;
  localparam logic [IW-1:0]     INT_FIM = IW'(INTERVALO - 1);
  localparam logic [SEL_W-1:0]  SEL_FIM = SEL_W'(NUM_CHARS - 1);

  if (NUM_CHARS < 1 || INTERVALO < 1 || TIMEOUT < 1) begin : g_param_chk
    $error("trena_uc_multi: NUM_CHARS, INTERVALO and TIMEOUT must all be >= 1");
  end

  t_estado          r_estado;
  t_estado          w_prox;
  logic [SEL_W-1:0] r_sel;
  logic [IW-1:0]    r_int;
  logic             w_int_fim;
  logic             w_ult_char;

  assign w_int_fim  = (r_int == INT_FIM);
  assign w_ult_char = (r_sel == SEL_FIM);

`ifdef TRENA_TIMEOUT_EN
  localparam int            TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_FIM = TW'(TIMEOUT - 1);

  logic [TW-1:0] r_tmo;
  logic          w_tmo_fim;

  assign w_tmo_fim = (r_tmo == TO_FIM);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tmo <= '0;
    end else if (r_estado == PREPARA) begin
      r_tmo <= '0;
    end else if (r_estado == AGUARDA && !w_tmo_fim) begin
      r_tmo <= r_tmo + 1'b1;
    end
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado <= INICIAL;
    end else begin
      r_estado <= w_prox;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sel <= '0;
      r_int <= '0;
    end else begin
      case (r_estado)
        PREPARA: begin
          r_sel <= '0;
          r_int <= '0;
        end
        PROXIMO:      r_sel <= r_sel + 1'b1;
        INTERVALO_ST: if (!w_int_fim) r_int <= r_int + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      INICIAL:   if (mensurar) w_prox = PREPARA;
      PREPARA:   w_prox = DISPARA;
      DISPARA:   w_prox = AGUARDA;
      AGUARDA: begin
        if (pronto) w_prox = TRANSMITE;
`ifdef TRENA_TIMEOUT_EN
        else if (w_tmo_fim) w_prox = ERRO;
`endif
      end
      TRANSMITE: w_prox = ESPERA_TX;
      ESPERA_TX: if (tx_pronto) w_prox = w_ult_char ? FINAL : PROXIMO;
      PROXIMO:   w_prox = TRANSMITE;
      FINAL:     w_prox = modo ? INTERVALO_ST : INICIAL;
      // modo dropping wins over the counter reaching its end
      INTERVALO_ST: begin
        if (!modo)          w_prox = INICIAL;
        else if (w_int_fim) w_prox = PREPARA;
      end
`ifdef TRENA_TIMEOUT_EN
      ERRO:      if (mensurar) w_prox = PREPARA;
`endif
      default:   w_prox = INICIAL;
    endcase
  end

  assign zera          = (r_estado == PREPARA);
  assign comeca_medida = (r_estado == DISPARA);
  assign tx_partida    = (r_estado == TRANSMITE);
  assign fim           = (r_estado == FINAL);
  assign sel_char      = r_sel;
  assign db_estado     = r_estado;
`ifdef TRENA_TIMEOUT_EN
  assign erro          = (r_estado == ERRO);
`else
  assign erro          = 1'b0;
`endif

endmodule

// File: tb/tb_trena_uc_multi.sv
// Directed self-checking bench for trena_uc_multi (NUM_CHARS=4, INTERVALO=20, TIMEOUT=100).
module tb_trena_uc_multi;

  localparam int NC = 4;
  localparam int IV = 20;
  localparam int TO = 100;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       mensurar = 1'b0;
  logic       modo = 1'b0;
  logic       pronto = 1'b0;
  logic       tx_pronto = 1'b0;
  logic       zera, comeca_medida, tx_partida, fim, erro;
  logic [1:0] sel_char;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;
  int n_tx = 0, n_fim = 0, n_com = 0;

  trena_uc_multi #(.NUM_CHARS(NC), .INTERVALO(IV), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .mensurar(mensurar), .modo(modo),
    .pronto(pronto), .tx_pronto(tx_pronto), .zera(zera),
    .comeca_medida(comeca_medida), .tx_partida(tx_partida),
    .sel_char(sel_char), .fim(fim), .erro(erro), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (tx_partida)    n_tx++;
    if (fim)           n_fim++;
    if (comeca_medida) n_com++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_state(input string tag, input logic [3:0] code, input int budget);
    int k;
    k = 0;
    while (db_estado !== code && k < budget) begin
      tick();
      k++;
    end
    chk(tag, db_estado, code);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_st"},   db_estado, 4'd0);
    chk({tag, "_outs"}, {zera, comeca_medida, tx_partida, fim, erro}, 5'b0);
    chk({tag, "_sel"},  sel_char, 2'd0);
  endtask

  // Pulses mensurar from INICIAL/ERRO and walks to AGUARDA
  task automatic start_to_aguarda(input string tag);
    mensurar = 1'b1;
    tick();
    mensurar = 1'b0;
    chk({tag, "_prep"}, {db_estado, zera}, {4'd1, 1'b1});
    tick();
    chk({tag, "_disp"}, {db_estado, comeca_medida}, {4'd2, 1'b1});
    tick();
    chk({tag, "_agu"}, db_estado, 4'd3);
  endtask

  int t0, f0, c0;

  initial begin
    // reset state
    ticks(3);
    chk_idle("rst");
    reset = 1'b0;
    tick();
    chk_idle("rst_rel");
    tick();
    chk_idle("rst_rel2");

    // 1. single shot with manual TX handshake
    t0 = n_tx; f0 = n_fim;
    modo = 1'b0;
    start_to_aguarda("t1");
    ticks(29);
    chk("t1_wait_pronto", db_estado, 4'd3);
    pronto = 1'b1;
    tick();
    pronto = 1'b0;
    for (int i = 0; i < NC; i++) begin
      chk($sformatf("t1_tx%0d", i), {db_estado, tx_partida}, {4'd4, 1'b1});
      chk($sformatf("t1_sel%0d", i), sel_char, i);
      tick();
      chk($sformatf("t1_esp%0d", i), {db_estado, tx_partida}, {4'd5, 1'b0});
      ticks(4);
      chk($sformatf("t1_hold%0d", i), db_estado, 4'd5);
      tx_pronto = 1'b1;
      tick();
      tx_pronto = 1'b0;
      if (i < NC - 1) begin
        chk($sformatf("t1_prox%0d", i), db_estado, 4'd6);
        tick();
      end
    end
    chk("t1_final", {db_estado, fim, sel_char}, {4'd7, 1'b1, 2'd3});
    tick();
    chk("t1_back", {db_estado, fim}, {4'd0, 1'b0});
    chk("t1_ntx", n_tx - t0, 4);
    chk("t1_nfim", n_fim - f0, 1);

    // 6. held inputs: two back-to-back single-shot runs of 16 cycles each
    t0 = n_tx; f0 = n_fim; c0 = n_com;
    mensurar = 1'b1; pronto = 1'b1; tx_pronto = 1'b1;
    ticks(32);
    chk("t6_st", db_estado, 4'd0);
    mensurar = 1'b0; pronto = 1'b0; tx_pronto = 1'b0;
    tick();
    chk("t6_stays", db_estado, 4'd0);
    chk("t6_ntx", n_tx - t0, 8);
    chk("t6_nfim", n_fim - f0, 2);
    chk("t6_ncom", n_com - c0, 2);

    // 2. continuous mode: 20-cycle interval, then drop modo
    modo = 1'b1;
    start_to_aguarda("t2");
    pronto = 1'b1;
    tick();
    pronto = 1'b0;
    tx_pronto = 1'b1;
    wait_state("t2_fim", 4'd7, 50);
    tick();
    chk("t2_int_in", db_estado, 4'd8);
    ticks(IV - 1);
    chk("t2_int_last", db_estado, 4'd8);
    tick();
    chk("t2_rezera", {db_estado, zera}, {4'd1, 1'b1});
    tick();
    chk("t2_recomeca", {db_estado, comeca_medida}, {4'd2, 1'b1});
    tick();
    pronto = 1'b1;
    tick();
    pronto = 1'b0;
    wait_state("t2_fim2", 4'd7, 50);
    tick();
    chk("t2_int2", db_estado, 4'd8);
    ticks(5);
    c0 = n_com;
    modo = 1'b0;
    tick();
    chk("t2_drop", db_estado, 4'd0);
    tx_pronto = 1'b0;
    ticks(30);
    chk("t2_no_com", n_com - c0, 0);
    chk("t2_idle", db_estado, 4'd0);

`ifdef TRENA_TIMEOUT_EN
    // 3. timeout after exactly TIMEOUT cycles in AGUARDA
    start_to_aguarda("t3");
    ticks(TO - 1);
    chk("t3_pre", {db_estado, erro}, {4'd3, 1'b0});
    tick();
    chk("t3_erro", {db_estado, erro}, {4'd9, 1'b1});
    modo = 1'b1;
    ticks(3);
    chk("t3_hold", {db_estado, erro}, {4'd9, 1'b1});
    modo = 1'b0;
    // 4. race: pronto on the last AGUARDA cycle
    start_to_aguarda("t4");
    chk("t4_erro_clr", erro, 1'b0);
    ticks(TO - 1);
    pronto = 1'b1;
    tick();
    pronto = 1'b0;
    chk("t4_race", {db_estado, erro}, {4'd4, 1'b0});
    tx_pronto = 1'b1;
    wait_state("t4_fim", 4'd7, 50);
    tx_pronto = 1'b0;
    tick();
    chk("t4_back", db_estado, 4'd0);
`else
    // 4. no timeout build: AGUARDA waits indefinitely
    start_to_aguarda("t4");
    ticks(10000);
    chk("t4_forever", {db_estado, erro}, {4'd3, 1'b0});
    pronto = 1'b1;
    tick();
    pronto = 1'b0;
    tx_pronto = 1'b1;
    wait_state("t4_fim", 4'd7, 50);
    tx_pronto = 1'b0;
    tick();
    chk("t4_back", db_estado, 4'd0);
`endif

    // 5. reset in ESPERA_TX with sel_char=2, then clean restart
    start_to_aguarda("t5");
    pronto = 1'b1;
    tick();
    pronto = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      tx_pronto = 1'b1;
      tick();
      tx_pronto = 1'b0;
      tick();
    end
    tick();
    chk("t5_pre", {db_estado, sel_char}, {4'd5, 2'd2});
    reset = 1'b1;
    #1;
    chk_idle("t5_async");
    tick();
    chk_idle("t5_rst");
    reset = 1'b0;
    tick();
    chk_idle("t5_rel");
    start_to_aguarda("t5b");
    pronto = 1'b1;
    tick();
    pronto = 1'b0;
    chk("t5_restart", {db_estado, tx_partida, sel_char}, {4'd4, 1'b1, 2'd0});
    tx_pronto = 1'b1;
    wait_state("t5_fim", 4'd7, 50);
    tx_pronto = 1'b0;
    chk("t5_lastsel", sel_char, 2'd3);
    tick();
    chk("t5_back", db_estado, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
